sample_accumulator: RTL and testbench

- Downstream consumer of the 8-bit sample stream produced by the edge-clocked register stage.
- Sums every NACC accepted samples into one wider result and emits it on a valid/ready output.
- Results pass through a 2-entry output buffer, so short consumer stalls do not throttle the producer.
- FLUSH emits a partial block early, e.g. at end of stream.

---
 rtl/sample_accumulator_pkg.sv | 29 ++
 rtl/sample_accumulator_fifo2.sv | 75 +++++++
 rtl/sample_accumulator.sv | 84 ++++++++
 tb/tb_sample_accumulator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sample_accumulator_pkg.sv
// Shared support definitions for the sample accumulator: width helpers and
// the output buffer occupancy encoding.
package sample_accumulator_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r++;
    end
    return r;
  endfunction

  // The block counter needs at least one bit even when NACC is 1.
  function automatic int cnt_width(input int nacc);
    return (clog2(nacc) < 1) ? 1 : clog2(nacc);
  endfunction

  function automatic int sum_width(input int nbits, input int nacc);
    return nbits + clog2(nacc);
  endfunction

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/sample_accumulator_fifo2.sv
// Two-entry register FIFO holding finished block sums; the head is a flop so
// the consumer sees a registered, stable value.
//
// state     | meaning
// BUF_EMPTY | nothing buffered, dout is don't-care
// BUF_ONE   | head valid, tail unused
// BUF_FULL  | head and tail both valid
module sum_fifo2
  import sample_accumulator_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          full
);

  buf_state_e    state_q, state_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = din;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = din;
        end else if (push) begin
          tail_d  = din;
          state_d = BUF_FULL;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // The producer is held off while full, so only a pop can happen here.
        if (pop) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  assign dout  = head_q;
  assign valid = (state_q != BUF_EMPTY);
  assign full  = (state_q == BUF_FULL);

endmodule

// File: rtl/sample_accumulator.sv
// Sums every NACC accepted samples into one wider result and hands it to a
// two-entry output buffer; FLUSH emits a partial block early.
module sample_accumulator
  import sample_accumulator_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int NACC  = 4
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic [NBITS-1:0]                   XIN,
  input  logic                               XIN_VALID,
  output logic                               XIN_READY,
  input  logic                               FLUSH,
  output logic [sum_width(NBITS, NACC)-1:0]  SUM,
  output logic                               SUM_VALID,
  input  logic                               SUM_READY
);

  localparam int OBITS = sum_width(NBITS, NACC);
  localparam int CNTW  = cnt_width(NACC);

  logic [OBITS-1:0] acc_q, acc_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [OBITS-1:0] nxt;
  logic             accept;
  logic             pop;
  logic             cnt_last;
  logic             complete;
  logic             flush_push;
  logic             push;
  logic             buf_full;
  logic             buf_valid;

  assign cnt_last = (cnt_q == CNTW'(NACC - 1));

  // Ready looks only at registered buffer state and FLUSH, never SUM_READY.
  assign XIN_READY = !(buf_full && (cnt_last || FLUSH));
  assign accept    = XIN_VALID && XIN_READY;
  assign pop       = buf_valid && SUM_READY;

  always_comb begin
    nxt        = acc_q + (accept ? OBITS'(XIN) : '0);
    complete   = accept && cnt_last;
    // A flush that finds the buffer full is dropped; the partial sum stays.
    flush_push = FLUSH && (cnt_q != '0 || accept) && !complete && !buf_full;
    push       = complete || flush_push;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    if (push) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = nxt;
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  sum_fifo2 #(
    .DW(OBITS)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RESET),
    .push (push),
    .pop  (pop),
    .din  (nxt),
    .dout (SUM),
    .valid(buf_valid),
    .full (buf_full)
  );

  assign SUM_VALID = buf_valid;

endmodule

// File: tb/tb_sample_accumulator.sv
// Directed bench for sample_accumulator with a queue-based reference model
// checked every cycle plus hand-computed spot checks.
module tb_sample_accumulator;

  localparam int NBITS = 8;
  localparam int NACC  = 4;
  localparam int OBITS = 10;

  logic             clk;
  logic             rst_n;
  logic [NBITS-1:0] xin;
  logic             xin_valid;
  logic             xin_ready;
  logic             flush;
  logic [OBITS-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;

  int checks;
  int errors;

  // Reference model: expected buffered sums and the block in progress.
  int exp_q[$];
  int blk_sum;
  int blk_n;

  sample_accumulator #(.NBITS(NBITS), .NACC(NACC)) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .XIN      (xin),
    .XIN_VALID(xin_valid),
    .XIN_READY(xin_ready),
    .FLUSH    (flush),
    .SUM      (sum),
    .SUM_VALID(sum_valid),
    .SUM_READY(sum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Compare on the falling edge, then advance the model across the next rising edge.
  always @(negedge clk) begin
    bit m_ready, m_accept, m_pop, m_complete, m_flush;
    int size_before;
    if (!rst_n) begin
      exp_q.delete();
      blk_sum = 0;
      blk_n   = 0;
    end else begin
      m_ready = !(exp_q.size() == 2 && (blk_n == NACC - 1 || flush));
      chk("model_sum_valid", int'(sum_valid), int'(exp_q.size() > 0));
      chk("model_xin_ready", int'(xin_ready), int'(m_ready));
      if (exp_q.size() > 0) chk("model_sum", int'(sum), exp_q[0]);

      m_accept    = xin_valid && m_ready;
      m_pop       = (exp_q.size() > 0) && sum_ready;
      size_before = exp_q.size();
      if (m_accept) begin
        blk_sum += int'(xin);
        blk_n++;
      end
      m_complete = m_accept && (blk_n == NACC);
      m_flush    = flush && !m_complete && blk_n != 0 && size_before < 2;
      if (m_pop) void'(exp_q.pop_front());
      if (m_complete || m_flush) begin
        exp_q.push_back(blk_sum);
        blk_sum = 0;
        blk_n   = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int value);
    int waited;
    xin       = NBITS'(value);
    xin_valid = 1'b1;
    waited    = 0;
    while (!xin_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!xin_ready) begin
      errors++;
      $display("FAIL send_timeout: xin_ready stuck at 0, sample %0d not accepted", value);
    end else begin
      step();
    end
    xin_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    xin       = '0;
    xin_valid = 1'b0;
    flush     = 1'b0;
    sum_ready = 1'b0;

    #2;
    chk("reset_sum_valid", int'(sum_valid), 0);
    chk("reset_sum", int'(sum), 0);
    step();
    rst_n = 1'b1;
    chk("reset_xin_ready", int'(xin_ready), 1);

    // Basic block and full-scale block
    sum_ready = 1'b1;
    send(10); send(20); send(30); send(40);
    chk("blk100_valid", int'(sum_valid), 1);
    chk("blk100_sum", int'(sum), 100);
    step();
    chk("blk100_popped", int'(sum_valid), 0);
    for (int i = 0; i < 4; i++) send(255);
    chk("blk1020_sum", int'(sum), 1020);
    step();

    // Back-pressure: two sums buffered, third block stalls at its last sample
    sum_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(1);
    xin       = 8'd1;
    xin_valid = 1'b1;
    chk("stall_xin_ready", int'(xin_ready), 0);
    chk("stall_head", int'(sum), 4);
    sum_ready = 1'b1;
    send(1);
    for (int i = 0; i < 4; i++) step();
    chk("stall_drained", int'(sum_valid), 0);

    // Flush of a partial block, then a flush with nothing pending
    send(5); send(6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush11_sum", int'(sum), 11);
    chk("flush11_valid", int'(sum_valid), 1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty_valid", int'(sum_valid), 0);
    step();
    chk("flush_empty_valid2", int'(sum_valid), 0);

    // Flush coinciding with the completing sample
    send(1); send(2); send(3);
    flush = 1'b1;
    send(4);
    flush = 1'b0;
    chk("flush_full_sum", int'(sum), 10);
    step();
    chk("flush_full_single", int'(sum_valid), 0);

    // Push and pop together while one entry is held
    sum_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1);
    send(2); send(2); send(2);
    chk("pushpop_old_head", int'(sum), 4);
    sum_ready = 1'b1;
    send(2);
    chk("pushpop_new_head", int'(sum), 8);
    chk("pushpop_valid", int'(sum_valid), 1);
    step();
    chk("pushpop_one_left", int'(sum_valid), 0);

    // Asynchronous reset mid-block with one buffered sum
    sum_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(7);
    send(1); send(1);
    chk("prereset_sum", int'(sum), 28);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(sum_valid), 0);
    chk("async_rst_sum", int'(sum), 0);
    step();
    rst_n     = 1'b1;
    sum_ready = 1'b1;
    chk("post_rst_ready", int'(xin_ready), 1);
    for (int i = 0; i < 4; i++) send(1);
    chk("post_rst_sum", int'(sum), 4);
    step();
    chk("post_rst_empty", int'(sum_valid), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
